// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU (MEM stage) vs host/debug loader.
// Grants are decoded combinationally; state, counters and read-return valids are registered.
module dmem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
    localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [LCW-1:0] lock_cnt;
    logic           wait_full;
    logic           lock_full;
    logic           force_cpu;
    logic           leave_lock;

    assign wait_full  = (wait_cnt == WCW'(MAX_WAIT));
    assign lock_full  = (lock_cnt == LCW'(LOCK_MAX));
    // Burst has used its quota and the CPU is waiting: hand the CPU one slot.
    assign force_cpu  = (state == ST_LOCK) && lock_full && cpu_req;
    assign leave_lock = force_cpu || !host_req || !host_lock;

    // Grant decode
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (state == ST_LOCK) begin
            if (force_cpu)     cpu_gnt  = 1'b1;
            else if (host_req) host_gnt = 1'b1;
            else if (cpu_req)  cpu_gnt  = 1'b1;
        end else begin
            if (host_req && (!cpu_req || wait_full)) host_gnt = 1'b1;
            else if (cpu_req)                        cpu_gnt  = 1'b1;
        end
    end

    // Memory port mux; idle bus is all zeros
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_write = cpu_we;
            mem_read  = !cpu_we;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_write = host_we;
            mem_read  = !host_we;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rdata  = mem_rdata;
    assign host_rdata = mem_rdata;

    // Arbitration state, starvation/burst counters and read-owner valids
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ARB;
            wait_cnt    <= '0;
            lock_cnt    <= '0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            cpu_rvalid  <= cpu_gnt & ~cpu_we;
            host_rvalid <= host_gnt & ~host_we;

            if (host_req && !host_gnt) begin
                if (!wait_full) wait_cnt <= wait_cnt + WCW'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (state == ST_ARB) begin
                if (host_gnt && host_lock) begin
                    state    <= ST_LOCK;
                    lock_cnt <= LCW'(1);
                end
            end else if (leave_lock) begin
                state    <= ST_ARB;
                lock_cnt <= '0;
            end else if (host_gnt && !lock_full) begin
                lock_cnt <= lock_cnt + LCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic against a
// behavioural model of who-wins rules, a reference memory and read-return expectations.
module tb_dmem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write, mem_read;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    // Single-port memory with registered read, MEM[i] = i at start
    logic [DW-1:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[5:0]];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: policy expressed as "how long has the host been refused"
    // and "how many grants has the current burst taken".
    int            denied;
    bit            in_burst;
    int            burst;
    bit            exp_crv, exp_hrv;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] ref_mem [0:63];
    bit            last_cg, last_hg;
    bit            seen_cg, seen_hg;

    task automatic model_reset();
        denied   = 0;
        in_burst = 0;
        burst    = 0;
        exp_crv  = 0;
        exp_hrv  = 0;
    endtask

    task automatic decide(output bit cg, output bit hg, output bit frc);
        cg  = 0;
        hg  = 0;
        frc = in_burst && (burst >= LOCK_MAX) && cpu_req;
        if (frc)                                              cg = 1;
        else if (in_burst && host_req)                        hg = 1;
        else if (host_req && (!cpu_req || denied >= MAX_WAIT)) hg = 1;
        else if (cpu_req)                                     cg = 1;
    endtask

    // One clock: compare everything at mid-low phase, then advance the model past posedge
    task automatic cycle();
        bit cg, hg, frc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        #1;
        decide(cg, hg, frc);
        ea = cg ? cpu_addr : (hg ? host_addr : '0);
        ew = cg ? cpu_wdata : (hg ? host_wdata : '0);
        check("cpu_gnt",     64'(cpu_gnt),   64'(cg));
        check("host_gnt",    64'(host_gnt),  64'(hg));
        check("cpu_stall",   64'(cpu_stall), 64'(cpu_req && !cg));
        check("mem_addr",    64'(mem_addr),  64'(ea));
        check("mem_wdata",   64'(mem_wdata), 64'(ew));
        check("mem_write",   64'(mem_write), 64'((cg && cpu_we) || (hg && host_we)));
        check("mem_read",    64'(mem_read),  64'((cg && !cpu_we) || (hg && !host_we)));
        check("cpu_rvalid",  64'(cpu_rvalid),  64'(exp_crv));
        check("host_rvalid", 64'(host_rvalid), 64'(exp_hrv));
        if (exp_crv) check("cpu_rdata",  64'(cpu_rdata),  64'(exp_rd));
        if (exp_hrv) check("host_rdata", 64'(host_rdata), 64'(exp_rd));
        seen_cg = cpu_gnt;
        seen_hg = host_gnt;
        last_cg = cg;
        last_hg = hg;
        @(posedge clk);
        exp_crv = cg && !cpu_we;
        exp_hrv = hg && !host_we;
        if (cg) begin
            if (cpu_we) ref_mem[cpu_addr[5:0]] = cpu_wdata;
            else        exp_rd = ref_mem[cpu_addr[5:0]];
        end else if (hg) begin
            if (host_we) ref_mem[host_addr[5:0]] = host_wdata;
            else         exp_rd = ref_mem[host_addr[5:0]];
        end
        denied = (host_req && !hg) ? ((denied + 1 > MAX_WAIT) ? MAX_WAIT : denied + 1) : 0;
        if (!in_burst) begin
            if (hg && host_lock) begin
                in_burst = 1;
                burst    = 1;
            end
        end else if (frc || !host_req || !host_lock) begin
            in_burst = 0;
            burst    = 0;
        end else if (hg && burst < LOCK_MAX) begin
            burst++;
        end
        @(negedge clk);
    endtask

    task automatic set_cpu(input bit r, input bit w, input int a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = AW'(a); cpu_wdata = d;
    endtask

    task automatic set_host(input bit r, input bit w, input bit l, input int a, input logic [DW-1:0] d);
        host_req = r; host_we = w; host_lock = l; host_addr = AW'(a); host_wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_cpu(0, 0, 0, '0);
        set_host(0, 0, 0, 0, '0);
        repeat (2) @(negedge clk);
        model_reset();
        #1;
        check("rst_cpu_gnt",  64'(cpu_gnt),     64'(0));
        check("rst_host_gnt", 64'(host_gnt),    64'(0));
        check("rst_mem_bus",  64'({mem_read, mem_write, cpu_stall}), 64'(0));
        check("rst_mem_addr", 64'(mem_addr),    64'(0));
        check("rst_rvalids",  64'({cpu_rvalid, host_rvalid}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = DW'(i);
        do_reset();

        // CPU read of address 5 returns the preloaded value
        set_cpu(1, 0, 5, '0);
        cycle();
        check("rd5_gnt", 64'(seen_cg), 64'(1));
        set_cpu(0, 0, 0, '0);
        #1;
        check("rd5_rvalid", 64'(cpu_rvalid), 64'(1));
        check("rd5_rdata",  64'(cpu_rdata),  64'(5));
        cycle();

        // Host write 0xABCD to 9, then CPU reads it back
        set_host(1, 1, 0, 9, 32'hABCD);
        cycle();
        check("hwr_gnt", 64'(seen_hg), 64'(1));
        set_host(0, 0, 0, 0, '0);
        set_cpu(1, 0, 9, '0);
        cycle();
        set_cpu(0, 0, 0, '0);
        #1;
        check("rd9_rdata", 64'(cpu_rdata), 64'(32'hABCD));
        cycle();

        // Continuous contention: host forced in every 5th cycle
        set_cpu(1, 0, 1, '0);
        set_host(1, 0, 0, 2, '0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("contend_host", 64'(seen_hg), 64'(i % 5 == 4));
        end
        set_cpu(0, 0, 0, '0);
        set_host(0, 0, 0, 0, '0);
        cycle();

        // Burst lock: 8 host grants, then one forced CPU slot
        set_host(1, 1, 1, 3, 32'h11);
        cycle();
        check("lock_first", 64'(seen_hg), 64'(1));
        set_cpu(1, 0, 4, '0);
        for (int i = 1; i < 9; i++) begin
            cycle();
            check("lock_seq", 64'({seen_cg, seen_hg}), (i < 8) ? 64'(1) : 64'(2));
            if (seen_cg) set_cpu(0, 0, 0, '0);
        end
        set_host(0, 0, 0, 0, '0);
        set_cpu(0, 0, 0, '0);
        cycle();

        // Lock released after 3 grants: next contended cycle goes to CPU
        set_host(1, 1, 1, 6, 32'h22);
        cycle();
        set_cpu(1, 0, 7, '0);
        cycle();
        host_lock = 1'b0;
        cycle();
        check("unlock_3rd_host", 64'(seen_hg), 64'(1));
        cycle();
        check("unlock_cpu_wins", 64'(seen_cg), 64'(1));
        set_cpu(0, 0, 0, '0);
        set_host(0, 0, 0, 0, '0);
        cycle();

        // Reset during a host read in lock mode: no rvalid, state back to ARB
        set_host(1, 0, 1, 8, '0);
        #1;
        check("rstrd_gnt", 64'(host_gnt), 64'(1));
        #1;
        rst = 1'b1;
        set_host(0, 0, 0, 0, '0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstrd_rvalid", 64'(host_rvalid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        set_cpu(1, 0, 10, '0);
        set_host(1, 0, 1, 11, '0);
        cycle();
        check("rstrd_arb", 64'(seen_cg), 64'(1));

        // Random traffic; requests held until granted
        for (int n = 0; n < 1500; n++) begin
            if (!cpu_req || last_cg)
                set_cpu($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), $urandom);
            if (!host_req || last_hg)
                set_host($urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)), host_lock,
                         int'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 7) == 0) host_lock = !host_lock;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
